// File: rtl/i2c_slave_regfile_if.sv
// Bus bundle for the I2C register-file target: pad side (scl/sda)
// and fabric side (host register port, commit notify, busy).
interface i2c_slave_regfile_if #(
    parameter int PTR_W = 4
);
    logic             scl_i;
    logic             sda_i;
    logic             sda_oe;
    logic             host_we;
    logic [PTR_W-1:0] host_addr;
    logic [7:0]       host_wdata;
    logic [7:0]       host_rdata;
    logic             i2c_wr_stb;
    logic [PTR_W-1:0] i2c_wr_addr;
    logic [7:0]       i2c_wr_data;
    logic             busy;

    modport master (
        output scl_i, sda_i, host_we, host_addr, host_wdata,
        input  sda_oe, host_rdata, i2c_wr_stb, i2c_wr_addr,
        input  i2c_wr_data, busy
    );

    modport slave (
        input  scl_i, sda_i, host_we, host_addr, host_wdata,
        output sda_oe, host_rdata, i2c_wr_stb, i2c_wr_addr,
        output i2c_wr_data, busy
    );
endinterface

// File: rtl/i2c_slave_regfile.sv
// I2C target with a byte-wide register file, register pointer and
// auto-increment, plus a local host port onto the same registers.
// Ports: clk; rstn (synchronous, active-low); bus (slave modport):
//   scl_i/sda_i async pad inputs, sda_oe open-drain low enable,
//   host_we/host_addr/host_wdata write, host_rdata comb read,
//   i2c_wr_stb/i2c_wr_addr/i2c_wr_data commit pulse, busy START..STOP.
module i2c_slave_regfile #(
    parameter logic [6:0] I2C_ADDRESS = 7'h53,
    parameter int         NUM_REGS    = 16,
    parameter int         PTR_W       = 4,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] RESET_VAL   = 8'h00
) (
    input logic                clk,
    input logic                rstn,
    i2c_slave_regfile_if.slave bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RMACK, S_IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
    logic                   r_scl_q, r_sda_q;
    logic [7:0]             r_regs [NUM_REGS];

    state_t           r_state, w_state_n;
    logic [3:0]       r_cnt, w_cnt_n;
    logic [7:0]       r_shift, w_shift_n;
    logic [7:0]       r_tx, w_tx_n;
    logic [PTR_W-1:0] r_ptr, w_ptr_n;
    logic             r_sda_oe, w_oe_n;
    logic             r_rw, w_rw_n;
    logic             r_mack, w_mack_n;
    logic             r_commit, w_commit_n;
    logic             r_busy, w_busy_n;
    logic             r_wr_stb;
    logic [PTR_W-1:0] r_wr_addr;
    logic [7:0]       r_wr_data;

    logic             w_scl, w_sda;
    logic             w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [PTR_W-1:0] w_ptr_inc;
    logic [7:0]       w_rd_byte;
    logic [2:0]       w_bit_idx;
    logic             w_ptr_ok;

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl & ~r_scl_q;
    assign w_scl_fall = ~w_scl & r_scl_q;
    // SDA edges only count as START/STOP while SCL is steadily high
    assign w_start    = w_scl & r_scl_q & r_sda_q & ~w_sda;
    assign w_stop     = w_scl & r_scl_q & ~r_sda_q & w_sda;

    assign w_ptr_inc = (r_ptr == PTR_W'(NUM_REGS - 1)) ?
                       '0 : r_ptr + PTR_W'(1);
    assign w_rd_byte = r_regs[r_ptr];
    assign w_bit_idx = 3'd7 - r_cnt[2:0];
    assign w_ptr_ok  = {1'b0, r_shift} < 9'(NUM_REGS);

    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_shift_n  = r_shift;
        w_tx_n     = r_tx;
        w_ptr_n    = r_ptr;
        w_oe_n     = r_sda_oe;
        w_rw_n     = r_rw;
        w_mack_n   = r_mack;
        w_commit_n = 1'b0;
        w_busy_n   = r_busy;
        if (r_commit)
            w_ptr_n = w_ptr_inc;
        unique case (r_state)
            S_ADDR, S_PTR, S_WDATA: begin
                if (w_scl_rise && r_cnt != 4'd8) begin
                    w_shift_n = {r_shift[6:0], w_sda};
                    w_cnt_n   = r_cnt + 4'd1;
                end else if (w_scl_fall && r_cnt == 4'd8) begin
                    w_cnt_n = '0;
                    if (r_state == S_ADDR) begin
                        if (r_shift[7:1] == I2C_ADDRESS) begin
                            w_state_n = S_ADDR_ACK;
                            w_oe_n    = 1'b1;
                            w_rw_n    = r_shift[0];
                        end else begin
                            w_state_n = S_IGNORE;
                        end
                    end else if (r_state == S_PTR) begin
                        if (w_ptr_ok) begin
                            w_ptr_n   = PTR_W'(r_shift);
                            w_oe_n    = 1'b1;
                            w_state_n = S_PTR_ACK;
                        end else begin
                            w_oe_n    = 1'b0;
                            w_state_n = S_IGNORE;
                        end
                    end else begin
                        w_oe_n     = 1'b1;
                        w_commit_n = 1'b1;
                        w_state_n  = S_WDATA_ACK;
                    end
                end
            end
            S_ADDR_ACK: begin
                if (w_scl_fall) begin
                    w_cnt_n = '0;
                    if (r_rw) begin
                        // byte is frozen here; later host writes miss it
                        w_tx_n    = w_rd_byte;
                        w_oe_n    = ~w_rd_byte[7];
                        w_state_n = S_RDATA;
                    end else begin
                        w_oe_n    = 1'b0;
                        w_state_n = S_PTR;
                    end
                end
            end
            S_PTR_ACK, S_WDATA_ACK: begin
                if (w_scl_fall) begin
                    w_cnt_n   = '0;
                    w_oe_n    = 1'b0;
                    w_state_n = S_WDATA;
                end
            end
            S_RDATA: begin
                if (w_scl_rise && r_cnt != 4'd8) begin
                    w_cnt_n = r_cnt + 4'd1;
                end else if (w_scl_fall && r_cnt == 4'd8) begin
                    w_cnt_n   = '0;
                    w_oe_n    = 1'b0;
                    w_ptr_n   = w_ptr_inc;
                    w_state_n = S_RMACK;
                end else if (w_scl_fall && r_cnt != 4'd0) begin
                    w_oe_n = ~r_tx[w_bit_idx];
                end
            end
            S_RMACK: begin
                if (w_scl_rise) begin
                    w_mack_n = w_sda;
                end else if (w_scl_fall) begin
                    w_cnt_n = '0;
                    if (!r_mack) begin
                        w_tx_n    = w_rd_byte;
                        w_oe_n    = ~w_rd_byte[7];
                        w_state_n = S_RDATA;
                    end else begin
                        w_oe_n    = 1'b0;
                        w_state_n = S_IGNORE;
                    end
                end
            end
            default: begin
                w_oe_n = 1'b0;
            end
        endcase
        if (w_start) begin
            w_state_n = S_ADDR;
            w_cnt_n   = '0;
            w_oe_n    = 1'b0;
            w_busy_n  = 1'b1;
        end else if (w_stop) begin
            w_state_n = S_IDLE;
            w_oe_n    = 1'b0;
            w_busy_n  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_q    <= 1'b1;
            r_sda_q    <= 1'b1;
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_tx       <= '0;
            r_ptr      <= '0;
            r_sda_oe   <= 1'b0;
            r_rw       <= 1'b0;
            r_mack     <= 1'b1;
            r_commit   <= 1'b0;
            r_busy     <= 1'b0;
            r_wr_stb   <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            for (int i = 0; i < NUM_REGS; i++)
                r_regs[i] <= RESET_VAL;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], bus.scl_i};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], bus.sda_i};
            r_scl_q    <= w_scl;
            r_sda_q    <= w_sda;
            r_state    <= w_state_n;
            r_cnt      <= w_cnt_n;
            r_shift    <= w_shift_n;
            r_tx       <= w_tx_n;
            r_ptr      <= w_ptr_n;
            r_sda_oe   <= w_oe_n;
            r_rw       <= w_rw_n;
            r_mack     <= w_mack_n;
            r_commit   <= w_commit_n;
            r_busy     <= w_busy_n;
            r_wr_stb   <= r_commit;
            if (r_commit) begin
                r_wr_addr <= r_ptr;
                r_wr_data <= r_shift;
            end
            if (bus.host_we)
                r_regs[bus.host_addr] <= bus.host_wdata;
            // later assignment wins a same-index collision
            if (r_commit)
                r_regs[r_ptr] <= r_shift;
        end
    end

    assign bus.sda_oe      = r_sda_oe;
    assign bus.host_rdata  = r_regs[bus.host_addr];
    assign bus.i2c_wr_stb  = r_wr_stb;
    assign bus.i2c_wr_addr = r_wr_addr;
    assign bus.i2c_wr_data = r_wr_data;
    assign bus.busy        = r_busy;

endmodule
